banked_sync_ram: RTL and testbench

BANKED_SYNC_RAM -- requirements
Module: banked_sync_ram

---
 rtl/banked_sync_ram.sv | 108 ++++++++++
 tb/tb_banked_sync_ram.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/banked_sync_ram.sv
// Banked single-port synchronous RAM with a request/response handshake.
// The top BANK_BITS address bits select a bank and the rest index a word inside it.
// Each bank has its own enable. Accesses to a disabled bank are counted. Such a write
// is dropped, and such a read answers with zero data and the error flag set.
module banked_sync_ram #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    parameter int BANK_BITS  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [ADDR_WIDTH-1:0]       req_addr,
    input  logic [DATA_WIDTH-1:0]       req_wdata,
    input  logic [DATA_WIDTH/8-1:0]     req_be,
    input  logic [(2**BANK_BITS)-1:0]   bank_en,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic                        rsp_err,
    output logic [15:0]                 err_count
);

    localparam int NUM_BANKS  = 2 ** BANK_BITS;
    localparam int IDX_WIDTH  = ADDR_WIDTH - BANK_BITS;
    localparam int BANK_DEPTH = 2 ** IDX_WIDTH;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    // Storage is not reset; contents are undefined until written.
    logic [DATA_WIDTH-1:0] mem [NUM_BANKS][BANK_DEPTH];

    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic [15:0]           err_count_q, err_count_d;

    logic [BANK_BITS-1:0]  bank_sel;
    logic [IDX_WIDTH-1:0]  bank_idx;
    logic                  bank_ok;
    logic                  accept;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_word;

    // Decode the request and derive the handshake.
    always_comb begin
        bank_sel  = req_addr[ADDR_WIDTH-1 -: BANK_BITS];
        bank_idx  = req_addr[IDX_WIDTH-1:0];
        bank_ok   = bank_en[bank_sel];
        req_ready = !rsp_valid_q || rsp_ready;
        accept    = req_valid && req_ready;
        wr_en     = accept && req_we && bank_ok;
        rd_word   = mem[bank_sel][bank_idx];
    end

    // Byte-lane write into the selected bank. Lanes that are not enabled hold their value.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < BE_WIDTH; i++) begin
                if (req_be[i]) begin
                    mem[bank_sel][bank_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response slot and error counter next-state logic.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        err_count_d = err_count_q;
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        // A read accepted on the same edge as a consumed response reloads the slot directly.
        if (accept && !req_we) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = bank_ok ? rd_word : '0;
            rsp_err_d   = !bank_ok;
        end
        if (accept && !bank_ok && (err_count_q != '1)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    // Response and counter registers. Reset clears them at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_banked_sync_ram.sv
// Directed bench for banked_sync_ram (ADDR_WIDTH=8, DATA_WIDTH=32, BANK_BITS=2).
module tb_banked_sync_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic [3:0]  bank_en;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

    banked_sync_ram #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .BANK_BITS  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .bank_en   (bank_en),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
    endtask

    initial begin
        rst_n     = 1'b0;
        bank_en   = 4'hF;
        rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);

        // Reset state
        #3;
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
        chk("rst_err_count", {16'b0, err_count}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

        // Full write, then read the same address on the next cycle
        drive(1'b1, 1'b1, 8'h45, 32'hDEADBEEF, 4'hF);
        tick();
        chk("wr_no_rsp", {31'b0, rsp_valid}, 32'd0);
        drive(1'b1, 1'b0, 8'h45, 32'h0, 4'h0);
        tick();
        chk("rd1_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rd1_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("rd1_err",   {31'b0, rsp_err}, 32'd0);
        drive(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        tick();
        chk("rd1_drain", {31'b0, rsp_valid}, 32'd0);

        // Write only byte lane 0
        drive(1'b1, 1'b1, 8'h45, 32'h000000AA, 4'h1);
        tick();
        drive(1'b1, 1'b0, 8'h45, 32'h0, 4'h0);
        tick();
        chk("lane_rdata", rsp_rdata, 32'hDEADBEAA);

        // Boundary addresses land in separate banks; a write with no byte enables changes nothing
        drive(1'b1, 1'b1, 8'h3F, 32'h11111111, 4'hF);
        tick();
        drive(1'b1, 1'b1, 8'h40, 32'h22222222, 4'hF);
        tick();
        drive(1'b1, 1'b1, 8'hFF, 32'h33333333, 4'hF);
        tick();
        drive(1'b1, 1'b1, 8'hFF, 32'hFFFFFFFF, 4'h0);
        tick();
        drive(1'b1, 1'b0, 8'h3F, 32'h0, 4'h0);
        tick();
        chk("alias_3f", rsp_rdata, 32'h11111111);
        drive(1'b1, 1'b0, 8'h40, 32'h0, 4'h0);
        tick();
        chk("alias_40", rsp_rdata, 32'h22222222);
        chk("alias_40_valid", {31'b0, rsp_valid}, 32'd1);
        drive(1'b1, 1'b0, 8'hFF, 32'h0, 4'h0);
        tick();
        chk("alias_ff", rsp_rdata, 32'h33333333);
        chk("be0_no_err", {16'b0, err_count}, 32'd0);

        // Bank 1 is disabled: the write is dropped and the read reports an error
        bank_en = 4'b1101;
        drive(1'b1, 1'b1, 8'h45, 32'h12345678, 4'hF);
        tick();
        chk("dis_wr_cnt", {16'b0, err_count}, 32'd1);
        chk("dis_wr_norsp", {31'b0, rsp_valid}, 32'd0);
        drive(1'b1, 1'b0, 8'h45, 32'h0, 4'h0);
        tick();
        chk("dis_rd_valid", {31'b0, rsp_valid}, 32'd1);
        chk("dis_rd_rdata", rsp_rdata, 32'd0);
        chk("dis_rd_err",   {31'b0, rsp_err}, 32'd1);
        chk("dis_rd_cnt",   {16'b0, err_count}, 32'd2);

        // Stall with the error response pending; re-enabling the bank must not alter it
        rsp_ready = 1'b0;
        bank_en   = 4'hF;
        drive(1'b1, 1'b0, 8'h45, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_ready", {31'b0, req_ready}, 32'd0);
            chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
            chk("stall_rdata", rsp_rdata, 32'd0);
            chk("stall_err",   {31'b0, rsp_err}, 32'd1);
        end
        rsp_ready = 1'b1;
        #1;
        chk("unstall_ready", {31'b0, req_ready}, 32'd1);
        tick();
        chk("b2b0_valid", {31'b0, rsp_valid}, 32'd1);
        chk("b2b0_rdata", rsp_rdata, 32'hDEADBEAA);
        chk("b2b0_err",   {31'b0, rsp_err}, 32'd0);
        chk("b2b0_cnt",   {16'b0, err_count}, 32'd2);
        drive(1'b1, 1'b0, 8'h40, 32'h0, 4'h0);
        tick();
        chk("b2b1_valid", {31'b0, rsp_valid}, 32'd1);
        chk("b2b1_rdata", rsp_rdata, 32'h22222222);

        // Asynchronous reset while a response is pending
        drive(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        rsp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, rsp_valid}, 32'd0);
        chk("arst_cnt",   {16'b0, err_count}, 32'd0);
        chk("arst_rdata", rsp_rdata, 32'd0);
        chk("arst_err",   {31'b0, rsp_err}, 32'd0);
        #1 rst_n = 1'b1;
        tick();
        chk("arst_ready", {31'b0, req_ready}, 32'd1);
        chk("arst_valid2", {31'b0, rsp_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
